// File: rtl/sync_fifo_flagged_if.sv
// Bus bundle between a FIFO client and sync_fifo_flagged.
// The client drives requests and write data; the FIFO returns read data,
// occupancy flags and error pulses.
interface sync_fifo_flagged_if #(
    parameter int DATA_LEN   = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  flush;
    logic                  wr_en;
    logic [DATA_LEN-1:0]   data_in;
    logic                  rd_en;
    logic [DATA_LEN-1:0]   data_out;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, wr_en, data_in, rd_en,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with registered read data, occupancy flags and
// one-cycle overflow/underflow pulses. DEPTH need not be a power of two:
// pointers wrap explicitly at DEPTH-1. A write into a full FIFO is still
// accepted when a read is accepted on the same edge; a read of an empty
// FIFO is always rejected (no write-to-read bypass).
module sync_fifo_flagged #(
    parameter int DATA_LEN   = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AFULL_TH   = DEPTH - 2,
    parameter int AEMPTY_TH  = 2
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    sync_fifo_flagged_if.slave bus
);
    localparam int CNT_W = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] LP_ADDR_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] LP_ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      LP_CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]      LP_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      LP_CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      LP_CNT_AFULL = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0]      LP_CNT_AEMPT = CNT_W'(AEMPTY_TH);

    logic [DATA_LEN-1:0]   r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_LEN-1:0]   r_data_out;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_almost_full;
    logic                  w_almost_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_wr_rej;
    logic                  w_rd_rej;
    logic [ADDR_WIDTH-1:0] w_wr_addr_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_addr_nxt;
    logic [CNT_W-1:0]      w_count_nxt;

    // Occupancy flags come straight from the registered count.
    always_comb begin
        w_full         = (r_count == LP_CNT_FULL);
        w_empty        = (r_count == LP_CNT_ZERO);
        w_almost_full  = (r_count >= LP_CNT_AFULL);
        w_almost_empty = (r_count <= LP_CNT_AEMPT);
    end

    // Accept/reject decisions; flush swallows both requests without error.
    always_comb begin
        w_rd_acc = bus.rd_en && !w_empty && !bus.flush;
        w_wr_acc = bus.wr_en && (!w_full || w_rd_acc) && !bus.flush;
        w_wr_rej = bus.wr_en && !w_wr_acc && !bus.flush;
        w_rd_rej = bus.rd_en && !w_rd_acc && !bus.flush;
    end

    // Next pointer values wrap at DEPTH-1, not at 2^ADDR_WIDTH.
    always_comb begin
        w_wr_addr_nxt = (r_wr_addr == LP_ADDR_LAST) ? LP_ADDR_ZERO : r_wr_addr + LP_ADDR_ONE;
        w_rd_addr_nxt = (r_rd_addr == LP_ADDR_LAST) ? LP_ADDR_ZERO : r_rd_addr + LP_ADDR_ONE;
    end

    // Count moves only when exactly one side is accepted.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + LP_CNT_ONE;
            2'b01:   w_count_nxt = r_count - LP_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array: written on accepted writes only, never reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_addr] <= bus.data_in;
        end
    end

    // Pointers and count; flush clears them but leaves data_out and storage.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_addr <= LP_ADDR_ZERO;
            r_rd_addr <= LP_ADDR_ZERO;
            r_count   <= LP_CNT_ZERO;
        end else if (bus.flush) begin
            r_wr_addr <= LP_ADDR_ZERO;
            r_rd_addr <= LP_ADDR_ZERO;
            r_count   <= LP_CNT_ZERO;
        end else begin
            if (w_wr_acc) begin
                r_wr_addr <= w_wr_addr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_addr <= w_rd_addr_nxt;
            end
            r_count <= w_count_nxt;
        end
    end

    // Registered read port: data_out holds its value until the next accepted read.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_addr];
            end
            r_rd_valid <= w_rd_acc;
        end
    end

    // Error pulses last exactly one cycle after a rejected request.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_wr_rej;
            r_underflow <= w_rd_rej;
        end
    end

    // Drive the bus outputs.
    always_comb begin
        bus.data_out     = r_data_out;
        bus.rd_valid     = r_rd_valid;
        bus.full         = w_full;
        bus.empty        = w_empty;
        bus.almost_full  = w_almost_full;
        bus.almost_empty = w_almost_empty;
        bus.count        = r_count;
        bus.overflow     = r_overflow;
        bus.underflow    = r_underflow;
    end
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Bench for sync_fifo_flagged: a DEPTH=8 and a DEPTH=6 instance receive the
// same stimulus; a queue-based model predicts every output each cycle, and
// directed steps carry hand-computed literal expectations.
module tb_sync_fifo_flagged;
    logic clk;
    logic rst_n;

    sync_fifo_flagged_if #(.DATA_LEN(8), .ADDR_WIDTH(3)) if8 ();
    sync_fifo_flagged_if #(.DATA_LEN(8), .ADDR_WIDTH(3)) if6 ();

    sync_fifo_flagged #(.DATA_LEN(8), .DEPTH(8), .ADDR_WIDTH(3)) u_dut8 (
        .clk       (clk),
        .sys_rst_n (rst_n),
        .bus       (if8)
    );

    sync_fifo_flagged #(.DATA_LEN(8), .DEPTH(6), .ADDR_WIDTH(3)) u_dut6 (
        .clk       (clk),
        .sys_rst_n (rst_n),
        .bus       (if6)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    bit         in_flush, in_wr, in_rd;
    logic [7:0] in_data;

    logic [7:0] m_q0[$];
    logic [7:0] m_q1[$];
    logic [7:0] m_dout [2];
    bit         m_rdv  [2];
    bit         m_ovf  [2];
    bit         m_udf  [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q0.delete();
        m_q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_dout[k] = 8'h00;
            m_rdv[k]  = 1'b0;
            m_ovf[k]  = 1'b0;
            m_udf[k]  = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        logic [7:0] q[$];
        int depth;
        bit rd_ok, wr_ok;
        if (k == 0) q = m_q0; else q = m_q1;
        depth = (k == 0) ? 8 : 6;
        if (in_flush) begin
            q.delete();
            m_rdv[k] = 1'b0;
            m_ovf[k] = 1'b0;
            m_udf[k] = 1'b0;
        end else begin
            rd_ok = in_rd && (q.size() > 0);
            wr_ok = in_wr && ((q.size() < depth) || rd_ok);
            if (rd_ok) m_dout[k] = q.pop_front();
            if (wr_ok) q.push_back(in_data);
            m_rdv[k] = rd_ok;
            m_ovf[k] = in_wr && !wr_ok;
            m_udf[k] = in_rd && !rd_ok;
        end
        if (k == 0) m_q0 = q; else m_q1 = q;
    endtask

    task automatic drive(input bit f, input bit w, input bit r, input logic [7:0] d);
        in_flush = f; in_wr = w; in_rd = r; in_data = d;
        if8.flush = f; if8.wr_en = w; if8.rd_en = r; if8.data_in = d;
        if6.flush = f; if6.wr_en = w; if6.rd_en = r; if6.data_in = d;
    endtask

    // One clock: advance the model on the edge, return 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end else begin
            model_reset();
        end
        #1;
    endtask

    task automatic compare_one(input int k);
        int cnt, depth;
        string s;
        cnt   = (k == 0) ? m_q0.size() : m_q1.size();
        depth = (k == 0) ? 8 : 6;
        s     = (k == 0) ? "d8" : "d6";
        if (k == 0) begin
            chk({s, "_count"},    int'(if8.count),        cnt);
            chk({s, "_full"},     int'(if8.full),         int'(cnt == depth));
            chk({s, "_empty"},    int'(if8.empty),        int'(cnt == 0));
            chk({s, "_afull"},    int'(if8.almost_full),  int'(cnt >= depth - 2));
            chk({s, "_aempty"},   int'(if8.almost_empty), int'(cnt <= 2));
            chk({s, "_dout"},     int'(if8.data_out),     int'(m_dout[k]));
            chk({s, "_rdvalid"},  int'(if8.rd_valid),     int'(m_rdv[k]));
            chk({s, "_overflow"}, int'(if8.overflow),     int'(m_ovf[k]));
            chk({s, "_underflow"},int'(if8.underflow),    int'(m_udf[k]));
        end else begin
            chk({s, "_count"},    int'(if6.count),        cnt);
            chk({s, "_full"},     int'(if6.full),         int'(cnt == depth));
            chk({s, "_empty"},    int'(if6.empty),        int'(cnt == 0));
            chk({s, "_afull"},    int'(if6.almost_full),  int'(cnt >= depth - 2));
            chk({s, "_aempty"},   int'(if6.almost_empty), int'(cnt <= 2));
            chk({s, "_dout"},     int'(if6.data_out),     int'(m_dout[k]));
            chk({s, "_rdvalid"},  int'(if6.rd_valid),     int'(m_rdv[k]));
            chk({s, "_overflow"}, int'(if6.overflow),     int'(m_ovf[k]));
            chk({s, "_underflow"},int'(if6.underflow),    int'(m_udf[k]));
        end
    endtask

    // Per-cycle model comparison on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                compare_one(0);
                compare_one(1);
            end
        end
    end

    task automatic reset_literals(input string tag);
        chk({tag, "_count"},  int'(if8.count),        0);
        chk({tag, "_empty"},  int'(if8.empty),        1);
        chk({tag, "_aempty"}, int'(if8.almost_empty), 1);
        chk({tag, "_full"},   int'(if8.full),         0);
        chk({tag, "_afull"},  int'(if8.almost_full),  0);
        chk({tag, "_dout"},   int'(if8.data_out),     0);
        chk({tag, "_rdvalid"},int'(if8.rd_valid),     0);
        chk({tag, "_ovf"},    int'(if8.overflow),     0);
        chk({tag, "_udf"},    int'(if8.underflow),    0);
    endtask

    initial begin
        int sent, recv;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        reset_literals("rst");
        chk_en = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        // Fill with 0x01..0x08; almost_full from count 6.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(i));
            step();
            chk("fill_count", int'(if8.count), i);
            chk("fill_afull", int'(if8.almost_full), int'(i >= 6));
        end
        chk("fill_full", int'(if8.full), 1);
        drive(1'b0, 1'b1, 1'b0, 8'h09);
        step();
        chk("ovf_pulse", int'(if8.overflow), 1);
        chk("ovf_count", int'(if8.count), 8);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        chk("ovf_clear", int'(if8.overflow), 0);

        // Drain: 0x01..0x08 in order, then an underflowing read.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h00);
            step();
            chk("drain_dout", int'(if8.data_out), i);
            chk("drain_rdvalid", int'(if8.rd_valid), 1);
        end
        chk("drain_empty", int'(if8.empty), 1);
        step();
        chk("udf_pulse", int'(if8.underflow), 1);
        chk("udf_dout_hold", int'(if8.data_out), 8'h08);
        chk("udf_rdvalid", int'(if8.rd_valid), 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();

        // Full with simultaneous read and write of 0xAA.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
            step();
        end
        drive(1'b0, 1'b1, 1'b1, 8'hAA);
        step();
        chk("fullrw_count", int'(if8.count), 8);
        chk("fullrw_ovf", int'(if8.overflow), 0);
        chk("fullrw_dout", int'(if8.data_out), 8'h11);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h00);
            step();
            if (i < 7) chk("fullrw_seq", int'(if8.data_out), 8'h12 + i);
        end
        chk("fullrw_last", int'(if8.data_out), 8'hAA);
        chk("fullrw_empty", int'(if8.empty), 1);

        // Empty with simultaneous read and write of 0x55.
        drive(1'b0, 1'b1, 1'b1, 8'h55);
        step();
        chk("emptyrw_udf", int'(if8.underflow), 1);
        chk("emptyrw_count", int'(if8.count), 1);
        chk("emptyrw_rdvalid", int'(if8.rd_valid), 0);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        step();
        chk("emptyrw_read", int'(if8.data_out), 8'h55);
        chk("emptyrw_rdv", int'(if8.rd_valid), 1);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();

        // 20 words interleaved through the DEPTH=6 instance across wrap.
        sent = 0;
        recv = 0;
        for (int i = 0; i < 200 && recv < 20; i++) begin
            bit w, r;
            r = (i >= 8) && (m_q1.size() > 0) && (((i % 3) != 0) || (sent >= 20));
            w = (sent < 20) && ((i % 4) != 3) && ((m_q1.size() < 6) || r);
            drive(1'b0, w, r, 8'(8'hC0 + sent));
            if (w) sent++;
            step();
            if (if6.rd_valid) begin
                chk("wrap_order", int'(if6.data_out), 8'hC0 + recv);
                recv++;
            end
            chk("wrap_cnt_le6", int'(int'(if6.count) <= 6), 1);
        end
        chk("wrap_recv", recv, 20);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();

        // Count 5, then flush with requests that must be ignored.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(8'hE0 + i));
            step();
        end
        chk("preflush_count", int'(if8.count), 5);
        drive(1'b1, 1'b1, 1'b1, 8'hEE);
        step();
        chk("flush_count", int'(if8.count), 0);
        chk("flush_empty", int'(if8.empty), 1);
        chk("flush_ovf", int'(if8.overflow), 0);
        chk("flush_udf", int'(if8.underflow), 0);
        chk("flush_dout_hold", int'(if8.data_out), 8'hD3);
        chk("flush_rdvalid", int'(if8.rd_valid), 0);

        // Mid-burst asynchronous reset.
        drive(1'b0, 1'b1, 1'b0, 8'h31);
        step();
        drive(1'b0, 1'b1, 1'b1, 8'h32);
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        reset_literals("midrst");
        step();
        rst_n = 1'b1;

        // After release, storage starts fresh.
        drive(1'b0, 1'b1, 1'b0, 8'h77);
        step();
        drive(1'b0, 1'b1, 1'b0, 8'h78);
        step();
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        step();
        chk("postrst_rd0", int'(if8.data_out), 8'h77);
        step();
        chk("postrst_rd1", int'(if8.data_out), 8'h78);
        chk("postrst_empty", int'(if8.empty), 1);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
